// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Byte-level command handshake between a host-side client and the
//   PS/2 host transmitter.
//   tx_data  : command byte, taken when tx_valid and tx_ready are both high
//   tx_valid : client requests a send
//   tx_ready : transmitter idle and able to take a byte
//   busy     : transmitter owns the bus (any state but idle)
//   tx_done  : one-cycle pulse, device acknowledged the byte
//   tx_error : one-cycle pulse, no acknowledge or transfer timed out
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 command transmitter. Inhibits the clock, drives
//   the start bit, then shifts data/parity/stop on device clock falling
//   edges and reports the device acknowledge.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   ps2_clk     : raw PS/2 clock pin level
//   ps2_data    : raw PS/2 data pin level
//   ps2_clk_oe  : 1 pulls the PS/2 clock pin low (open drain)
//   ps2_data_oe : 1 pulls the PS/2 data pin low (open drain)
//   tx_if       : command handshake (slave side)
//
//   state     | meaning
//   IDLE      | lines released, ready for a byte
//   INHIBIT   | clock held low for inhibit_cycles
//   START     | clock released, start bit (data low) driven
//   DATA      | data bits, LSB first, one per falling edge
//   PARITY    | odd parity bit
//   STOP      | data released (stop bit); ack sampled on next edge
//   ACK       | report done/error from the sampled ack bit
//   WAIT_IDLE | wait for clock and data both high
module ps2_host_tx #(
    parameter int clk_freq       = 50_000_000,
    parameter int inhibit_cycles = 5000,
    parameter int timeout_cycles = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic ps2_clk_oe,
    output logic ps2_data_oe,
    ps2_host_tx_if.slave tx_if
);

    if (clk_freq <= 0) begin : g_bad_clk_freq
        $error("ps2_host_tx: clk_freq must be positive");
    end

    localparam int INH_W = $clog2(inhibit_cycles);
    localparam int TMO_W = $clog2(timeout_cycles + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(inhibit_cycles - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(timeout_cycles);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [2:0]       idx_q, idx_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ack_q, ack_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic fe;

    logic clk_oe, data_oe, ready, done, err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_q     <= '0;
            par_q      <= 1'b0;
            idx_q      <= '0;
            inh_q      <= '0;
            tmo_q      <= '0;
            ack_q      <= 1'b0;
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            clk_prev_q <= 1'b0;
            data_s1_q  <= 1'b0;
            data_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            idx_q      <= idx_d;
            inh_q      <= inh_d;
            tmo_q      <= tmo_d;
            ack_q      <= ack_d;
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fe = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        par_d   = par_q;
        idx_d   = idx_q;
        inh_d   = inh_q;
        tmo_d   = tmo_q;
        ack_d   = ack_q;
        clk_oe  = 1'b0;
        data_oe = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (tx_if.tx_valid) begin
                    byte_d  = tx_if.tx_data;
                    par_d   = ~^tx_if.tx_data;
                    inh_d   = INH_LOAD;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (inh_q == '0) begin
                    tmo_d   = TMO_LOAD;
                    idx_d   = '0;
                    state_d = S_START;
                end else begin
                    inh_d = inh_q - 1'b1;
                end
            end
            S_START: begin
                data_oe = 1'b1;
                if (fe) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                data_oe = ~byte_q[idx_q];
                if (fe) begin
                    if (idx_q == 3'd7) state_d = S_PARITY;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            S_PARITY: begin
                data_oe = ~par_q;
                if (fe) state_d = S_STOP;
            end
            S_STOP: begin
                // The device pulls data low before its last falling edge;
                // capture the line on that edge and report it next cycle.
                if (fe) begin
                    ack_d   = data_s2_q;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                done    = ~ack_q;
                err     = ack_q;
                state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout overrides any transfer-phase decision, including ACK.
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK}) begin
            if (tmo_q == '0) begin
                clk_oe  = 1'b0;
                data_oe = 1'b0;
                done    = 1'b0;
                err     = 1'b1;
                state_d = S_WAIT_IDLE;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    assign ps2_clk_oe     = clk_oe;
    assign ps2_data_oe    = data_oe;
    assign tx_if.tx_ready = ready;
    assign tx_if.busy     = (state_q != S_IDLE);
    assign tx_if.tx_done  = done;
    assign tx_if.tx_error = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 1000;
    localparam int H   = 20;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         par;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_w, ps2_data_w;
    logic ps2_clk_oe, ps2_data_oe;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit both_seen = 1'b0;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .clk_freq       (50_000_000),
        .inhibit_cycles (INH),
        .timeout_cycles (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk_w),
        .ps2_data    (ps2_data_w),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_if       (tx_if)
    );

    assign ps2_clk_w  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_w = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_if.tx_done) done_cnt++;
        if (tx_if.tx_error) err_cnt++;
        if (tx_if.tx_done && tx_if.tx_error) both_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        tick();
        tx_if.tx_valid = 1'b0;
    endtask

    // Counts cycles with the clock inhibited; returns at the negedge of the
    // first cycle after the inhibit with the data drive level seen there.
    task automatic wait_start(output int inh_len, output logic data_oe_after);
        int n = 0;
        @(negedge clk);
        while (ps2_clk_oe && n < INH + 100) begin
            n++;
            @(negedge clk);
        end
        inh_len       = n;
        data_oe_after = ps2_data_oe;
    endtask

    // Device model: n_edges clock pulses; bit k of frame is the data line
    // level at the rising edge of pulse k (bit 0 = start bit before pulse 1).
    // With n_edges < 11 it returns with the clock still low.
    task automatic run_dev(input bit ack, input int n_edges, output logic [10:0] frame);
        frame = '1;
        repeat (5) tick();
        frame[0] = ps2_data_w;
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            repeat (H) tick();
            if (k == n_edges && n_edges < 11) return;
            dev_clk = 1'b1;
            repeat (2) tick();
            if (k <= 10) frame[k] = ps2_data_w;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (H - 2) tick();
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (!tx_if.tx_ready && w < 200) begin
            tick();
            w++;
        end
        chk(name, tx_if.tx_ready, 1);
    endtask

    task automatic do_vector(input vec_t v, input string tag);
        int d0, e0, n;
        logic dok;
        logic [10:0] frame;
        logic [10:0] exp_frame;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_frame = {1'b1, v.par, v.data, 1'b0};
        send(v.data);
        wait_start(n, dok);
        chk({tag, " inhibit_len"}, n, INH);
        chk({tag, " data_oe_after_inhibit"}, dok, 1);
        run_dev(v.ack, 11, frame);
        wait_ready({tag, " back_to_idle"});
        chk({tag, " frame"}, frame, exp_frame);
        chk({tag, " parity_bit"}, frame[9], v.par);
        chk({tag, " done_pulses"}, done_cnt - d0, v.exp_done);
        chk({tag, " error_pulses"}, err_cnt - e0, v.exp_err);
    endtask

    initial begin
        vec_t vecs[7];
        int d0, e0, n, t;
        logic dok;
        logic [10:0] frame;

        vecs[0] = '{data: 8'hF4, ack: 1'b1, par: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'hFF, ack: 1'b1, par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{data: 8'h01, ack: 1'b1, par: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'h00, ack: 1'b1, par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{data: 8'h55, ack: 1'b1, par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{data: 8'hF4, ack: 1'b0, par: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{data: 8'hED, ack: 1'b1, par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        repeat (3) tick();
        chk("reset tx_ready", tx_if.tx_ready, 1);
        chk("reset busy", tx_if.busy, 0);
        chk("reset clk_oe", ps2_clk_oe, 0);
        chk("reset data_oe", ps2_data_oe, 0);
        chk("reset done_err", {tx_if.tx_done, tx_if.tx_error}, 0);
        reset = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 7; i++) begin
            do_vector(vecs[i], $sformatf("vec%0d", i));
            repeat (5) tick();
        end

        // Request during a transfer is ignored: the frame still carries 0xF4.
        d0 = done_cnt;
        send(8'hF4);
        wait_start(n, dok);
        tick();
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b1;
        repeat (10) tick();
        chk("busy_ignore ready", tx_if.tx_ready, 0);
        chk("busy_ignore busy", tx_if.busy, 1);
        tx_if.tx_valid = 1'b0;
        run_dev(1'b1, 11, frame);
        wait_ready("busy_ignore back_to_idle");
        chk("busy_ignore frame", frame, {1'b1, 1'b0, 8'hF4, 1'b0});
        chk("busy_ignore done", done_cnt - d0, 1);
        repeat (5) tick();

        // Device never clocks.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h12);
        wait_start(n, dok);
        t = 0;
        while (!tx_if.tx_error && t < TMO + 20) begin
            @(negedge clk);
            t++;
        end
        chk("timeout cycles", t, TMO);
        @(negedge clk);
        chk("timeout lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        tick();
        wait_ready("timeout back_to_idle");
        chk("timeout done", done_cnt - d0, 0);
        chk("timeout error", err_cnt - e0, 1);
        repeat (5) tick();

        // Reset after the fifth falling edge.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        wait_start(n, dok);
        run_dev(1'b1, 5, frame);
        chk("midreset busy_before", tx_if.busy, 1);
        reset = 1'b1;
        #1;
        chk("midreset lines", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("midreset pulses", {tx_if.tx_done, tx_if.tx_error}, 0);
        dev_clk = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("midreset ready", tx_if.tx_ready, 1);
        chk("midreset busy", tx_if.busy, 0);
        chk("midreset no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        repeat (5) tick();
        do_vector(vecs[6], "after_reset");

        chk("done_error_overlap", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
